epb_slave_sync: RTL and testbench
=================================

# epb_slave_sync

Registered, parametrised EPB slave front end for the FPGA side of the processor's external peripheral bus. It owns the pad-side tristate data and ready pins and registers every EPB input once. It converts each chip-select assertion into one strobe/acknowledge transaction on the internal register bus and generates the EPB ready pulse. Compared with the previous unregistered buffer shell, it adds configurable data/address widths, a transaction state machine, and an ack timeout. It sits between the EPB pads and the internal register/BRAM decode.

## Interface
Parameters:
- DATA_WIDTH, 16: EPB and internal data width. Must be a multiple of 16.
- ADDR_WIDTH, 23: EPB address width.
- GP_WIDTH, 6: general-purpose address extension width.
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before a forced completion. Range 2..65535.

Ports (clocking: one clock; reset is synchronous and active-low):
- epb_clk  in  1  EPB clock.
- epb_rst_n  in  1  synchronous active-low reset.
- epb_data_buf  inout  DATA_WIDTH  pad data bus.
- epb_oe_n_buf  in  1  pad output enable, active low.
- epb_cs_n_buf  in  1  pad chip select, active low.
- epb_r_w_n_buf  in  1  pad direction; 1 = read.
- epb_be_n_buf  in  DATA_WIDTH/8  pad byte enables, active low.
- epb_addr_buf  in  ADDR_WIDTH  pad address.
- epb_addr_gp_buf  in  GP_WIDTH  pad address extension.
- epb_rdy_buf  out  1  pad ready; tristate, high-Z when not enabled.
- bus_stb  out  1  internal request strobe.
- bus_we  out  1  internal write enable.
- bus_addr  out  GP_WIDTH+ADDR_WIDTH  {gp, addr}.
- bus_sel  out  DATA_WIDTH/8  byte selects, active high (inverted be_n).
- bus_wr_data  out  DATA_WIDTH  write data.
- bus_rd_data  in  DATA_WIDTH  read data; valid when bus_ack is high.
- bus_ack  in  1  one-cycle completion from the internal slave.
- busy  out  1  high whenever the state is not IDLE.
- timeout_count  out  8  saturating count of timed-out transactions.

## Operation
- Every pad input is registered once (the "_r" stage). All decisions use the registered values.
- The start condition is a falling edge of cs_n_r. The previous-cs register resets to 0, so a chip select already held low when reset is released never starts a transaction.
- FSM states: IDLE, WAIT, RDY, HOLD.
  - IDLE -> WAIT on the start condition. In the same edge, capture bus_addr, bus_we = ~r_w_n_r, bus_sel = ~be_n_r and bus_wr_data = data_in_r, and set bus_stb = 1.
  - WAIT: hold bus_stb and all captured outputs stable.
    - bus_ack = 1: clear bus_stb, latch bus_rd_data into the read register, go to RDY.
    - cs_n_r = 1 (abort): clear bus_stb, go to IDLE, ignore any later ack.
  - RDY: drive the ready level 1 for exactly one cycle, then go to HOLD.
  - HOLD: ready level 0 while still enabled. Go to IDLE when cs_n_r = 1.
- The ready output enable is high in RDY and HOLD, and also in WAIT (driving 0). When it is low, epb_rdy_buf is Z.
- The data bus is driven with the read register only when all of these hold: r_w_n_r = 1, oe_n_r = 0, cs_n_r = 0, and the state is RDY or HOLD. Otherwise it is Z.
- A simultaneous bus_ack and cs_n_r deassertion in WAIT counts as an abort: go to IDLE and assert no ready.
- Reset values: bus_stb=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wr_data=0, busy=0, timeout_count=0, ready output enable=0, data output enable=0, read register=0, state=IDLE.
- Reset asserted in the middle of a transaction returns the block to these values on the next edge. No ready pulse is emitted.

## Timing
- Let E be the edge at which cs_n_r is first sampled low.
  - bus_stb is high from edge E+1.
  - If bus_ack is high during cycle E+k (k ≥ 1), the state is RDY after edge E+k+1 and the ready pulse is high for that one cycle.
  - Minimum pad-to-ready latency is therefore 3 clocks, counting the input register.
- Read data is valid on the pad from the same cycle as the ready pulse and stays valid until cs_n_r or oe_n_r deasserts.
- Back-to-back transactions require cs_n_r to be sampled high for at least one cycle between them.

## Configuration
- EPB_TIMEOUT_EN defined:
  - A 16-bit counter runs while in WAIT. When it reaches TIMEOUT_CYCLES with no ack: clear bus_stb, load the read register with the 16'hDEAD pattern replicated DATA_WIDTH/16 times, increment timeout_count (saturating at 255), and go to RDY.
  - The counter clears on every entry to WAIT.
- EPB_TIMEOUT_EN undefined: WAIT lasts until ack or abort, with no counter, and timeout_count is tied to 0.

## Test plan
- Write with DATA_WIDTH=32, addr=0x12345, gp=0x01, be_n=4'b0000, data=0xA5A5_0F0F, ack on the 2nd WAIT cycle -> bus_we=1, bus_sel=4'hF, bus_addr={6'h01,23'h12345}, one ready pulse, bus_stb high for exactly 2 cycles.
- Read with ack returning 0xCAFEBABE -> pad data = 0xCAFEBABE from the ready cycle until cs_n rises, then Z. epb_rdy_buf returns to Z after cs_n_r is high.
- With EPB_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no ack -> ready pulse, read data 0xDEADDEAD, timeout_count 0 -> 1. Repeat 300 times -> timeout_count saturates at 255.
- cs_n deasserted in WAIT, with ack arriving in the same cycle -> no ready pulse, state IDLE, busy=0.
- epb_rst_n pulsed low in HOLD while cs_n is held low -> all outputs at reset values. No new transaction starts until cs_n goes high and then low again.
- Two back-to-back reads separated by a single high cs_n cycle -> two separate strobes and two ready pulses.

Source files
------------

// File: rtl/epb_slave_sync.sv
// Registered EPB slave front end: one internal strobe/ack transaction per chip-select assertion.
// Define EPB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES wait cycles without an ack.
module epb_slave_sync #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 23,
    parameter int unsigned GP_WIDTH       = 6,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           epb_clk,
    input  logic                           epb_rst_n,
    inout  wire logic [DATA_WIDTH-1:0]     epb_data_buf,
    input  logic                           epb_oe_n_buf,
    input  logic                           epb_cs_n_buf,
    input  logic                           epb_r_w_n_buf,
    input  logic [DATA_WIDTH/8-1:0]        epb_be_n_buf,
    input  logic [ADDR_WIDTH-1:0]          epb_addr_buf,
    input  logic [GP_WIDTH-1:0]            epb_addr_gp_buf,
    output wire logic                      epb_rdy_buf,
    output logic                           bus_stb,
    output logic                           bus_we,
    output logic [GP_WIDTH+ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH/8-1:0]        bus_sel,
    output logic [DATA_WIDTH-1:0]          bus_wr_data,
    input  logic [DATA_WIDTH-1:0]          bus_rd_data,
    input  logic                           bus_ack,
    output logic                           busy,
    output logic [7:0]                     timeout_count
);

    if (DATA_WIDTH == 0 || DATA_WIDTH % 16 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a nonzero multiple of 16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {StIdle, StWait, StRdy, StHold} state_e;

    state_e                  state;
    logic [DATA_WIDTH-1:0]   data_in_r;
    logic                    oe_n_r;
    logic                    cs_n_r;
    logic                    r_w_n_r;
    logic [DATA_WIDTH/8-1:0] be_n_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [GP_WIDTH-1:0]     gp_r;
    logic                    cs_n_prev;
    logic                    rdy_oe;
    logic                    rdy_lvl;
    logic [DATA_WIDTH-1:0]   rd_reg;
    logic                    data_oe;
    logic                    start;

`ifdef EPB_TIMEOUT_EN
    localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
    logic [7:0]  timeouts;
    assign timeout_count = timeouts;
`else
    assign timeout_count = 8'd0;
`endif

    // Pad input stage; the datapath needs no reset, only the previous-cs flop does.
    always_ff @(posedge epb_clk) begin
        data_in_r <= epb_data_buf;
        oe_n_r    <= epb_oe_n_buf;
        cs_n_r    <= epb_cs_n_buf;
        r_w_n_r   <= epb_r_w_n_buf;
        be_n_r    <= epb_be_n_buf;
        addr_r    <= epb_addr_buf;
        gp_r      <= epb_addr_gp_buf;
    end

    // cs_n_prev resets low so a chip select held through reset never looks like a new edge.
    assign start = cs_n_prev & ~cs_n_r;

    always_ff @(posedge epb_clk) begin
        if (!epb_rst_n) begin
            state       <= StIdle;
            cs_n_prev   <= 1'b0;
            bus_stb     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_sel     <= '0;
            bus_wr_data <= '0;
            rdy_oe      <= 1'b0;
            rdy_lvl     <= 1'b0;
            rd_reg      <= '0;
`ifdef EPB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeouts    <= '0;
`endif
        end else begin
            cs_n_prev <= cs_n_r;
            case (state)
                StIdle: begin
                    if (start) begin
                        state       <= StWait;
                        bus_stb     <= 1'b1;
                        bus_we      <= ~r_w_n_r;
                        bus_addr    <= {gp_r, addr_r};
                        bus_sel     <= ~be_n_r;
                        bus_wr_data <= data_in_r;
                        rdy_oe      <= 1'b1;
                        rdy_lvl     <= 1'b0;
`ifdef EPB_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                StWait: begin
                    // Abort wins over a coincident ack: no ready is issued.
                    if (cs_n_r) begin
                        state   <= StIdle;
                        bus_stb <= 1'b0;
                        rdy_oe  <= 1'b0;
                    end else if (bus_ack) begin
                        state   <= StRdy;
                        bus_stb <= 1'b0;
                        rd_reg  <= bus_rd_data;
                        rdy_lvl <= 1'b1;
`ifdef EPB_TIMEOUT_EN
                    end else if (wait_cnt == WaitLast) begin
                        state   <= StRdy;
                        bus_stb <= 1'b0;
                        rd_reg  <= {(DATA_WIDTH / 16){16'hDEAD}};
                        rdy_lvl <= 1'b1;
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                StRdy: begin
                    state   <= StHold;
                    rdy_lvl <= 1'b0;
                end
                StHold: begin
                    if (cs_n_r) begin
                        state  <= StIdle;
                        rdy_oe <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign data_oe = r_w_n_r && !oe_n_r && !cs_n_r && (state == StRdy || state == StHold);
    assign busy    = (state != StIdle);

    assign epb_data_buf = data_oe ? rd_reg : 'z;
    assign epb_rdy_buf  = rdy_oe ? rdy_lvl : 1'bz;

endmodule

// File: tb/tb_epb_slave_sync.sv
// Bench for epb_slave_sync: vector table, random transactions against a transaction-level model,
// plus hand sequences for abort, reset-in-HOLD and (with EPB_TIMEOUT_EN) timeout saturation.
module tb_epb_slave_sync;

    localparam int DW = 32;
    localparam int AW = 23;
    localparam int GW = 6;
    localparam int BW = DW / 8;
    localparam int TO = 4;
`ifdef EPB_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    typedef struct {
        logic           is_wr;
        logic [AW-1:0]  a;
        logic [GW-1:0]  g;
        logic [BW-1:0]  ben;
        logic [DW-1:0]  wd;
        logic [DW-1:0]  rd;
        int             ack_k;     // WAIT cycle carrying the ack, 0 = never
        logic           oen;
        int             hold;
        logic [GW+AW-1:0] exp_addr;
        logic [BW-1:0]  exp_sel;
        int             exp_wait;  // cycles bus_stb stays high
        logic           exp_to;
        logic           exp_drv;
        logic [DW-1:0]  exp_pad;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          tb_drv;
    logic [DW-1:0] tb_data;
    logic          oe_n, cs_n, r_w_n;
    logic [BW-1:0] be_n;
    logic [AW-1:0] addr;
    logic [GW-1:0] gp;
    logic [DW-1:0] rd_data;
    logic          ack;
    wire  [DW-1:0] data_pad;
    wire           rdy_pad;
    logic          stb, we, busy;
    logic [GW+AW-1:0] baddr;
    logic [BW-1:0] sel;
    logic [DW-1:0] wdata;
    logic [7:0]    tcount;

    pullup (rdy_pad);
    assign data_pad = tb_drv ? tb_data : 'z;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tc = 0;
    vec_t tbl[5];

    epb_slave_sync #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GP_WIDTH(GW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .epb_clk(clk), .epb_rst_n(rst_n), .epb_data_buf(data_pad), .epb_oe_n_buf(oe_n),
        .epb_cs_n_buf(cs_n), .epb_r_w_n_buf(r_w_n), .epb_be_n_buf(be_n), .epb_addr_buf(addr),
        .epb_addr_gp_buf(gp), .epb_rdy_buf(rdy_pad), .bus_stb(stb), .bus_we(we),
        .bus_addr(baddr), .bus_sel(sel), .bus_wr_data(wdata), .bus_rd_data(rd_data),
        .bus_ack(ack), .busy(busy), .timeout_count(tcount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // A released pad reads 0 in a two-state simulator and Z in a four-state one.
    task automatic check_pad(input string name, input logic drv, input logic [DW-1:0] val);
        n_cmp++;
        if (drv ? (data_pad !== val) : !(data_pad === '0 || data_pad === 'z)) begin
            n_bad++;
            $display("FAIL %s: pad %h want %s", name, data_pad,
                     drv ? $sformatf("%h", val) : "released");
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " stb/we/busy"}, {stb, we, busy}, 3'b000);
        check({tag, " addr"}, baddr, 0);
        check({tag, " sel"}, sel, 0);
        check({tag, " wdata"}, wdata, 0);
        check({tag, " tcount"}, tcount, 0);
        check({tag, " rdy Z"}, rdy_pad, 1'b1);
        check_pad({tag, " pad"}, 1'b0, '0);
    endtask

    // Starts with cs_n_r high and the FSM idle (or leaving HOLD); ends one edge after cs_n rises.
    task automatic run_txn(input vec_t v, input string tag);
        r_w_n = !v.is_wr; oe_n = v.oen; be_n = v.ben; addr = v.a; gp = v.g;
        tb_drv = v.is_wr; tb_data = v.wd; cs_n = 1'b0;
        tick();
        check({tag, " idle"}, {busy, stb, rdy_pad}, 3'b001);
        tick();
        check({tag, " start"}, {busy, stb, we, rdy_pad}, {1'b1, 1'b1, v.is_wr, 1'b0});
        check({tag, " addr"}, baddr, v.exp_addr);
        check({tag, " sel"}, sel, v.exp_sel);
        if (v.is_wr) check({tag, " wdata"}, wdata, v.wd);
        tb_drv = 1'b0;
        for (int j = 1; j <= v.exp_wait; j++) begin
            check({tag, " wait"}, {stb, rdy_pad}, 2'b10);
            if (j == v.ack_k) begin
                ack = 1'b1;
                rd_data = v.rd;
            end
            tick();
            ack = 1'b0;
            rd_data = $urandom;
        end
        if (v.exp_to && exp_tc < 255) exp_tc++;
        check({tag, " rdy"}, {busy, stb, rdy_pad}, 3'b101);
        check({tag, " tcount"}, tcount, exp_tc);
        check_pad({tag, " rd pad"}, v.exp_drv, v.exp_pad);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({tag, " hold"}, {busy, stb, rdy_pad}, 3'b100);
            check_pad({tag, " hold pad"}, v.exp_drv, v.exp_pad);
        end
        cs_n = 1'b1;
        tick();
        check({tag, " release"}, {busy, rdy_pad}, 2'b10);
        check_pad({tag, " pad off"}, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 23'h12345, 6'h01, 4'h0, 32'hA5A50F0F, 32'h0, 2, 1'b0, 1,
                   {6'h01, 23'h12345}, 4'hF, 2, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 23'h00100, 6'h02, 4'h0, 32'h0, 32'hCAFEBABE, 1, 1'b0, 2,
                   {6'h02, 23'h00100}, 4'hF, 1, 1'b0, 1'b1, 32'hCAFEBABE};
        tbl[2] = '{1'b1, 23'h7FFFFF, 6'h3F, 4'b1010, 32'h12345678, 32'h0, 3, 1'b0, 0,
                   {6'h3F, 23'h7FFFFF}, 4'b0101, 3, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 23'h00042, 6'h00, 4'b0011, 32'h0, 32'h0BADF00D, 1, 1'b1, 1,
                   {6'h00, 23'h00042}, 4'b1100, 1, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 23'h00007, 6'h15, 4'h0, 32'h0, 32'h00000001, 4, 1'b0, 0,
                   {6'h15, 23'h00007}, 4'hF, 4, 1'b0, 1'b1, 32'h00000001};

        rst_n = 1'b0; cs_n = 1'b1; oe_n = 1'b1; r_w_n = 1'b1; be_n = '1; addr = '0; gp = '0;
        tb_drv = 1'b0; tb_data = '0; ack = 1'b0; rd_data = '0;
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Consecutive entries are separated by a single high cs_n cycle.
        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Abort: cs_n_r rises in the same WAIT cycle the ack arrives.
        r_w_n = 1'b1; oe_n = 1'b0; be_n = '0; addr = 23'h00ABC; gp = '0; cs_n = 1'b0;
        tick();
        tick();
        check("abort start", {stb, busy}, 2'b11);
        cs_n = 1'b1;
        tick();
        check("abort wait", stb, 1'b1);
        ack = 1'b1; rd_data = 32'h77778888;
        tick();
        ack = 1'b0;
        check("abort idle", {busy, stb, rdy_pad}, 3'b001);
        tick();
        check("abort no rdy", {busy, rdy_pad}, 2'b01);
        check_pad("abort pad", 1'b0, '0);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.is_wr = 1'($urandom_range(0, 1));
            v.a = AW'($urandom); v.g = GW'($urandom); v.ben = BW'($urandom);
            v.wd = $urandom; v.rd = $urandom | 32'h1;
            v.ack_k = $urandom_range(1, 6);
            v.oen = ($urandom_range(0, 3) == 0);
            v.hold = $urandom_range(0, 3);
            v.exp_to = TimeoutOn && (v.ack_k > TO);
            v.exp_wait = v.exp_to ? TO : v.ack_k;
            v.exp_addr = {v.g, v.a};
            v.exp_sel = ~v.ben;
            v.exp_drv = !v.is_wr && !v.oen;
            v.exp_pad = v.exp_to ? {2{16'hDEAD}} : v.rd;
            run_txn(v, $sformatf("rand%0d", i));
        end

        // Reset pulsed in HOLD with cs_n held low: no restart until cs_n toggles.
        r_w_n = 1'b0; oe_n = 1'b1; be_n = '0; addr = 23'h55555; gp = 6'h2A;
        tb_drv = 1'b1; tb_data = 32'h600DF00D; cs_n = 1'b0;
        tick();
        tick();
        tb_drv = 1'b0;
        check("rst pre stb", {stb, we}, 2'b11);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("rst pre hold", {busy, rdy_pad}, 2'b10);
        rst_n = 1'b0;
        tick();
        check_reset("rst mid");
        exp_tc = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst no restart", {busy, stb, rdy_pad}, 3'b001);
        end
        cs_n = 1'b1;
        tick();
        run_txn(tbl[0], "post rst");

`ifdef EPB_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v = tbl[1];
            v.ack_k = 0; v.hold = 0; v.exp_to = 1'b1; v.exp_wait = TO;
            v.exp_pad = {2{16'hDEAD}};
            run_txn(v, $sformatf("tmo%0d", i));
        end
        check("tcount saturated", tcount, 8'd255);
`endif

        tick();
        check("end idle", {busy, stb, rdy_pad}, 3'b001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
